// File: rtl/fp_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential bfloat16 multiplier.
// The issuing side uses the master modport; the multiplier uses the slave modport.
interface fp_mul_seq_if;
    logic        i_start;
    logic [15:0] i_opA;
    logic [15:0] i_opB;
    logic [15:0] o_product;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_inexact;
    logic        o_invalid;
    logic        o_valid;
    logic        o_busy;

    modport master (
        output i_start, i_opA, i_opB,
        input  o_product, o_overflow, o_underflow, o_inexact, o_invalid, o_valid, o_busy
    );

    modport slave (
        input  i_start, i_opA, i_opB,
        output o_product, o_overflow, o_underflow, o_inexact, o_invalid, o_valid, o_busy
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential bfloat16 multiplier: 8 shift-add cycles for the significand product,
// then one normalize/round cycle. Start/busy/valid handshake matches the divider.
module fp_mul_seq #(
    parameter logic [15:0] CANON_NAN = 16'h7FC0
) (
    input  logic          clk,
    input  logic          reset,
    fp_mul_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ROUND
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [15:0] r_opA;
    logic [15:0] r_opB;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;

    logic [15:0] r_product;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_inexact;
    logic        r_invalid;
    logic        r_valid;

    logic [7:0]  w_sigA;
    logic [7:0]  w_sigB;
    logic [15:0] w_partial;
    logic        w_multBit;

    logic [7:0]  w_expA;
    logic [7:0]  w_expB;
    logic        w_zeroA;
    logic        w_zeroB;
    logic        w_infA;
    logic        w_infB;
    logic        w_nanA;
    logic        w_nanB;
    logic        w_sign;

    logic signed [9:0] w_expSum;
    logic signed [9:0] w_eNorm;
    logic signed [9:0] w_eFinal;
    logic [6:0]  w_mNorm;
    logic [6:0]  w_mFinal;
    logic [7:0]  w_mRnd;
    logic        w_guard;
    logic        w_sticky;
    logic        w_roundUp;

    logic [15:0] w_product;
    logic        w_overflow;
    logic        w_underflow;
    logic        w_inexact;
    logic        w_invalid;

    assign w_sigA    = {1'b1, r_opA[6:0]};
    assign w_sigB    = {1'b1, r_opB[6:0]};
    assign w_partial = {8'h00, w_sigA} << r_cnt;
    assign w_multBit = w_sigB[r_cnt];

    assign w_expA  = r_opA[14:7];
    assign w_expB  = r_opB[14:7];
    assign w_zeroA = (w_expA == 8'h00);
    assign w_zeroB = (w_expB == 8'h00);
    assign w_infA  = (w_expA == 8'hFF) && (r_opA[6:0] == 7'h00);
    assign w_infB  = (w_expB == 8'hFF) && (r_opB[6:0] == 7'h00);
    assign w_nanA  = (w_expA == 8'hFF) && (r_opA[6:0] != 7'h00);
    assign w_nanB  = (w_expB == 8'hFF) && (r_opB[6:0] != 7'h00);
    assign w_sign  = r_opA[15] ^ r_opB[15];
    assign w_expSum = $signed({2'b00, w_expA}) + $signed({2'b00, w_expB});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_nextState = MUL;
            MUL:     if (r_cnt == 3'd7) w_nextState = ROUND;
            ROUND:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Normalize on the product's top bit, then round-to-nearest-even.
    always_comb begin
        w_mNorm  = 7'h00;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_eNorm  = 10'sd0;
        if (r_acc[15]) begin
            w_mNorm  = r_acc[14:8];
            w_guard  = r_acc[7];
            w_sticky = |r_acc[6:0];
            w_eNorm  = w_expSum - 10'sd126;
        end else begin
            w_mNorm  = r_acc[13:7];
            w_guard  = r_acc[6];
            w_sticky = |r_acc[5:0];
            w_eNorm  = w_expSum - 10'sd127;
        end
        w_roundUp = w_guard & (w_sticky | w_mNorm[0]);
        w_mRnd    = {1'b0, w_mNorm} + {7'h00, w_roundUp};
        w_mFinal  = w_mRnd[6:0];
        w_eFinal  = w_eNorm;
        if (w_mRnd[7]) begin
            w_mFinal = 7'h00;
            w_eFinal = w_eNorm + 10'sd1;
        end
    end

    // Special operands override the normal-path result and its flags.
    always_comb begin
        w_product   = 16'h0000;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        w_inexact   = 1'b0;
        w_invalid   = 1'b0;
        if (w_nanA || w_nanB || (w_infA && w_zeroB) || (w_zeroA && w_infB)) begin
            w_product = CANON_NAN;
            w_invalid = 1'b1;
        end else if (w_infA || w_infB) begin
            w_product = {w_sign, 8'hFF, 7'h00};
        end else if (w_zeroA || w_zeroB) begin
            w_product = {w_sign, 15'h0000};
        end else if (w_eFinal >= 10'sd255) begin
            w_product  = {w_sign, 8'hFF, 7'h00};
            w_overflow = 1'b1;
            w_inexact  = 1'b1;
        end else if (w_eFinal <= 10'sd0) begin
            w_product   = {w_sign, 15'h0000};
            w_underflow = 1'b1;
            w_inexact   = 1'b1;
        end else begin
            w_product = {w_sign, w_eFinal[7:0], w_mFinal};
            w_inexact = w_guard | w_sticky;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opA       <= 16'h0000;
            r_opB       <= 16'h0000;
            r_acc       <= 16'h0000;
            r_cnt       <= 3'd0;
            r_product   <= 16'h0000;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
            r_invalid   <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_opA <= bus.i_opA;
                        r_opB <= bus.i_opB;
                        r_acc <= 16'h0000;
                        r_cnt <= 3'd0;
                    end
                end
                MUL: begin
                    if (w_multBit) begin
                        r_acc <= r_acc + w_partial;
                    end
                    r_cnt <= r_cnt + 3'd1;
                end
                ROUND: begin
                    r_product   <= w_product;
                    r_overflow  <= w_overflow;
                    r_underflow <= w_underflow;
                    r_inexact   <= w_inexact;
                    r_invalid   <= w_invalid;
                    r_valid     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_product   = r_product;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;
    assign bus.o_inexact   = r_inexact;
    assign bus.o_invalid   = r_invalid;
    assign bus.o_valid     = r_valid;
    assign bus.o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: results, flags, latency and handshake.
// Flags are compared as {overflow, underflow, inexact, invalid}.
module tb_fp_mul_seq;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fp_mul_seq_if bus ();

    fp_mul_seq #(.CANON_NAN(16'h7FC0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.o_overflow, bus.o_underflow, bus.o_inexact, bus.o_invalid};
    endfunction

    // Launch one operation and wait (bounded) for valid; lat counts edges after the start edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        bus.i_opA   = a;
        bus.i_opB   = b;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_opA   = 16'h0000;
        bus.i_opB   = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (bus.o_product !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_product: got %h expected 0000", bus.o_product);
        end
        tests++;
        if ({flags(), bus.o_valid, bus.o_busy} !== 6'b000000) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: flags/valid/busy got %b expected 000000",
                     {flags(), bus.o_valid, bus.o_busy});
        end
    endtask

    task automatic test_latency();
        int badBusy = 0;
        int badValid = 0;
        bus.i_opA   = 16'h3F80;
        bus.i_opB   = 16'h3F80;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (bus.o_busy !== 1'b1) badBusy++;
            if (bus.o_valid !== 1'b0) badValid++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (badBusy != 0 || badValid != 0) begin
            fails++;
            $display("[TB] FAIL latency_window: busy-low cycles %0d early-valid cycles %0d expected 0/0",
                     badBusy, badValid);
        end
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL latency_done: valid=%b busy=%b expected valid=1 busy=0",
                     bus.o_valid, bus.o_busy);
        end
        tests++;
        if (bus.o_product !== 16'h3F80 || flags() !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL one_x_one: got %h flags %b expected 3F80 flags 0000",
                     bus.o_product, flags());
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_product !== 16'h3F80) begin
            fails++;
            $display("[TB] FAIL valid_pulse_hold: valid=%b product=%h expected valid=0 product=3F80",
                     bus.o_valid, bus.o_product);
        end
    endtask

    // Finite and special-operand vectors: {opA, opB, product, flags}.
    task automatic test_vectors();
        logic [15:0] va [12] = '{16'h3FC0, 16'hBF80, 16'h3F81, 16'h3FA0, 16'h3FC0, 16'h7F00,
                                 16'h0080, 16'h7F80, 16'hFF80, 16'h7FC1, 16'h0000, 16'h7F80};
        logic [15:0] vb [12] = '{16'h3FC0, 16'h4000, 16'h3F81, 16'h3F82, 16'h3F81, 16'h7F00,
                                 16'h0080, 16'h0000, 16'h3F80, 16'h3F80, 16'hC000, 16'hFF80};
        logic [15:0] vp [12] = '{16'h4010, 16'hC000, 16'h3F82, 16'h3FA2, 16'h3FC2, 16'h7F80,
                                 16'h0000, 16'h7FC0, 16'hFF80, 16'h7FC0, 16'h8000, 16'hFF80};
        logic [3:0]  vf [12] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1010,
                                 4'b0110, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        int lat;
        for (int i = 0; i < 12; i++) begin
            run_op(va[i], vb[i], lat);
            tests++;
            if (lat !== 9) begin
                fails++;
                $display("[TB] FAIL vec%0d_latency: got %0d expected 9", i, lat);
            end
            tests++;
            if (bus.o_product !== vp[i] || flags() !== vf[i]) begin
                fails++;
                $display("[TB] FAIL vec%0d %h*%h: got %h flags %b expected %h flags %b",
                         i, va[i], vb[i], bus.o_product, flags(), vp[i], vf[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        bus.i_opA   = 16'h3FC0;
        bus.i_opB   = 16'h3FC0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.i_opA   = 16'h4000;
        bus.i_opB   = 16'h4000;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = 3;
        while (bus.o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests++;
        if (lat !== 9 || bus.o_product !== 16'h4010 || flags() !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL ignored_start: lat %0d product %h flags %b expected 9 4010 0000",
                     lat, bus.o_product, flags());
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        run_op(16'hBF80, 16'h4000, lat1);
        tests++;
        if (lat1 !== 9 || bus.o_product !== 16'hC000) begin
            fails++;
            $display("[TB] FAIL b2b_first: lat %0d product %h expected 9 C000", lat1, bus.o_product);
        end
        run_op(16'h3F81, 16'h3F81, lat2);
        tests++;
        if (lat2 !== 9 || bus.o_product !== 16'h3F82 || flags() !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL b2b_second: lat %0d product %h flags %b expected 9 3F82 0010",
                     lat2, bus.o_product, flags());
        end
    endtask

    task automatic test_reset_abort();
        int seenValid = 0;
        bus.i_opA   = 16'h3FC0;
        bus.i_opB   = 16'h3FC0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tests++;
        if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_product !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_abort: busy=%b valid=%b product=%h expected 0 0 0000",
                     bus.o_busy, bus.o_valid, bus.o_product);
        end
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) seenValid++;
        end
        tests++;
        if (seenValid != 0 || bus.o_product !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_no_valid: valid pulses %0d product %h expected 0 0000",
                     seenValid, bus.o_product);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_latency();
        test_vectors();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
